fifo_param_prog: RTL and testbench

Parametrised successor to the fixed 6x8 FIFO: a synchronous single-clock FIFO with configurable width and depth, run-time programmable almost-full/almost-empty thresholds, an occupancy count and a sticky overflow/underflow error. It sits between the PCIe switching stages as the per-lane buffer. `fifo_pause` gives upstream logic back-pressure, and the registered pop output feeds the downstream arbiter.

---
 rtl/fifo_param_prog.sv | 128 ++++++++++++
 tb/tb_fifo_param_prog.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param_prog.sv
// fifo_param_prog -- synchronous single-clock FIFO with parametrised width and
// depth, run-time programmable almost-full / almost-empty thresholds, an
// occupancy count and a sticky overflow/underflow error flag.
//
// Parameters:
//   DATA_SIZE  word width in bits
//   MAIN_SIZE  depth in words (power of two, >= 4)
//   PTR_SIZE   log2(MAIN_SIZE)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   write         push request
//   read          pop request
//   data_in_push  push data
//   umbral_af     almost-full threshold (quasi-static)
//   umbral_ae     almost-empty threshold (quasi-static)
//   data_out_pop  registered popped word
//   valid_out     data_out_pop holds a word popped at the previous edge
//   occupancy     words stored, 0..MAIN_SIZE
//   fifo_empty    occupancy == 0
//   fifo_full     occupancy == MAIN_SIZE
//   almost_empty  occupancy <= umbral_ae
//   almost_full   occupancy >= umbral_af
//   fifo_pause    back-pressure to upstream, equals almost_full
//   fifo_error    sticky overflow/underflow, cleared only by reset
module fifo_param_prog #(
  parameter int DATA_SIZE = 8,
  parameter int MAIN_SIZE = 8,
  parameter int PTR_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in_push,
  input  logic [PTR_SIZE:0]    umbral_af,
  input  logic [PTR_SIZE:0]    umbral_ae,
  output logic [DATA_SIZE-1:0] data_out_pop,
  output logic                 valid_out,
  output logic [PTR_SIZE:0]    occupancy,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 fifo_pause,
  output logic                 fifo_error
);

  localparam logic [PTR_SIZE:0] LP_FULL_CNT = (PTR_SIZE+1)'(MAIN_SIZE);

  logic [DATA_SIZE-1:0] r_mem [MAIN_SIZE];
  logic [PTR_SIZE-1:0]  r_wr_ptr;
  logic [PTR_SIZE-1:0]  r_rd_ptr;
  logic [PTR_SIZE:0]    r_count;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_valid;
  logic                 r_error;

  logic w_empty;
  logic w_full;
  logic w_wa;
  logic w_ra;
  logic w_overflow;
  logic w_underflow;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL_CNT);

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign w_wa        = write & (~w_full | read);
  // An empty FIFO never pops, even with a simultaneous push (no fall-through).
  assign w_ra        = read & ~w_empty;
  assign w_overflow  = write & w_full & ~read;
  assign w_underflow = read & w_empty;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wa) begin
      r_mem[r_wr_ptr] <= data_in_push;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_wa) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_ra) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_valid    <= 1'b1;
      end else begin
        r_valid    <= 1'b0;
      end

      case ({w_wa, w_ra})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_overflow | w_underflow) begin
        r_error <= 1'b1;
      end
    end
  end

  // Flags are pure decodes of the count register and live threshold inputs.
  assign occupancy    = r_count;
  assign fifo_empty   = w_empty;
  assign fifo_full    = w_full;
  assign almost_empty = (r_count <= umbral_ae);
  assign almost_full  = (r_count >= umbral_af);
  assign fifo_pause   = almost_full;
  assign fifo_error   = r_error;
  assign data_out_pop = r_data_out;
  assign valid_out    = r_valid;

endmodule

// File: tb/tb_fifo_param_prog.sv
// Directed self-checking bench for fifo_param_prog (8x8 configuration).
module tb_fifo_param_prog;

  logic       clk;
  logic       reset;
  logic       write;
  logic       read;
  logic [7:0] data_in_push;
  logic [3:0] umbral_af;
  logic [3:0] umbral_ae;
  logic [7:0] data_out_pop;
  logic       valid_out;
  logic [3:0] occupancy;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       fifo_pause;
  logic       fifo_error;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fifo_param_prog #(
    .DATA_SIZE (8),
    .MAIN_SIZE (8),
    .PTR_SIZE  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .data_in_push (data_in_push),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .data_out_pop (data_out_pop),
    .valid_out    (valid_out),
    .occupancy    (occupancy),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_pause   (fifo_pause),
    .fifo_error   (fifo_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".occ"},   32'(occupancy),    0);
    chk({tag, ".empty"}, 32'(fifo_empty),   1);
    chk({tag, ".full"},  32'(fifo_full),    0);
    chk({tag, ".ae"},    32'(almost_empty), 1);
    chk({tag, ".af"},    32'(almost_full),  0);
    chk({tag, ".pause"}, 32'(fifo_pause),   0);
    chk({tag, ".err"},   32'(fifo_error),   0);
    chk({tag, ".valid"}, 32'(valid_out),    0);
    chk({tag, ".dout"},  32'(data_out_pop), 0);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; data_in_push = 8'h00;
    umbral_af = 4'd6; umbral_ae = 4'd2;

    // Reset and idle
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("idle");

    // Fill with 0x01..0x08
    for (int unsigned i = 1; i <= 8; i++) begin
      write = 1'b1; data_in_push = 8'(i);
      tick();
      chk("fill.occ",   32'(occupancy),    i);
      chk("fill.af",    32'(almost_full),  (i >= 6) ? 1 : 0);
      chk("fill.pause", 32'(fifo_pause),   (i >= 6) ? 1 : 0);
      chk("fill.full",  32'(fifo_full),    (i == 8) ? 1 : 0);
      chk("fill.ae",    32'(almost_empty), (i <= 2) ? 1 : 0);
      chk("fill.empty", 32'(fifo_empty),   0);
    end
    chk("fill.err", 32'(fifo_error), 0);

    // Overflow: 9th write alone
    data_in_push = 8'hFF;
    tick();
    write = 1'b0;
    chk("ovf.err",  32'(fifo_error), 1);
    chk("ovf.occ",  32'(occupancy),  8);
    chk("ovf.full", 32'(fifo_full),  1);

    // Drain 8 words, then underflow
    for (int unsigned i = 1; i <= 8; i++) begin
      read = 1'b1;
      tick();
      chk("drain.dout",  32'(data_out_pop), i);
      chk("drain.valid", 32'(valid_out),    1);
      chk("drain.occ",   32'(occupancy),    8 - i);
      chk("drain.ae",    32'(almost_empty), (8 - i <= 2) ? 1 : 0);
      chk("drain.empty", 32'(fifo_empty),   (i == 8) ? 1 : 0);
    end
    tick();
    read = 1'b0;
    chk("udf.valid", 32'(valid_out),    0);
    chk("udf.err",   32'(fifo_error),   1);
    chk("udf.occ",   32'(occupancy),    0);
    chk("udf.dout",  32'(data_out_pop), 8'h08);

    // Asynchronous reset clears the sticky error without a clock edge
    reset = 1'b1;
    #1;
    chk("arst.err", 32'(fifo_error), 0);
    reset = 1'b0;

    // Wrap-around: 5 in, 5 out, then 8 more across the pointer wrap
    for (int unsigned i = 0; i < 5; i++) begin
      write = 1'b1; data_in_push = 8'(8'h10 + i);
      tick();
    end
    write = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      read = 1'b1;
      tick();
      chk("wrap1.dout", 32'(data_out_pop), 8'h10 + i);
    end
    read = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      write = 1'b1; data_in_push = 8'(8'hA0 + i);
      tick();
    end
    write = 1'b0;
    chk("wrap.occ",  32'(occupancy), 8);
    chk("wrap.full", 32'(fifo_full), 1);
    for (int unsigned i = 0; i < 8; i++) begin
      read = 1'b1;
      tick();
      chk("wrap2.dout",  32'(data_out_pop), 8'hA0 + i);
      chk("wrap2.valid", 32'(valid_out),    1);
    end
    read = 1'b0;
    tick();
    chk("wrap.err",   32'(fifo_error), 0);
    chk("wrap.empty", 32'(fifo_empty), 1);

    // Fill with 0xB0..0xB7, exercise threshold corners while full
    for (int unsigned i = 0; i < 8; i++) begin
      write = 1'b1; data_in_push = 8'(8'hB0 + i);
      tick();
    end
    write = 1'b0;
    umbral_af = 4'd9;
    #1;
    chk("thr.af_over", 32'(almost_full), 0);
    umbral_af = 4'd8;
    #1;
    chk("thr.af_eq", 32'(almost_full), 1);
    umbral_af = 4'd6;

    // Full with read+write: both accepted
    read = 1'b1; write = 1'b1; data_in_push = 8'hC0;
    tick();
    read = 1'b0; write = 1'b0;
    chk("rwfull.occ",   32'(occupancy),    8);
    chk("rwfull.dout",  32'(data_out_pop), 8'hB0);
    chk("rwfull.valid", 32'(valid_out),    1);
    chk("rwfull.err",   32'(fifo_error),   0);
    for (int unsigned i = 1; i <= 8; i++) begin
      read = 1'b1;
      tick();
      chk("rwfull.drain", 32'(data_out_pop), (i == 8) ? 8'hC0 : 8'hB0 + i);
    end
    read = 1'b0;
    tick();

    // Empty with almost-empty threshold 0 follows fifo_empty
    umbral_ae = 4'd0;
    #1;
    chk("thr.ae0_empty", 32'(almost_empty), 1);

    // Empty with read+write: push only, underflow flagged
    read = 1'b1; write = 1'b1; data_in_push = 8'hD0;
    tick();
    read = 1'b0; write = 1'b0;
    chk("rwempty.occ",   32'(occupancy),    1);
    chk("rwempty.valid", 32'(valid_out),    0);
    chk("rwempty.err",   32'(fifo_error),   1);
    chk("rwempty.dout",  32'(data_out_pop), 8'hC0);
    chk("thr.ae0_one",   32'(almost_empty), 0);
    umbral_ae = 4'd2;

    reset = 1'b1;
    #1;
    reset = 1'b0;

    // Mid-burst asynchronous reset at occupancy 4
    for (int unsigned i = 0; i < 5; i++) begin
      write = 1'b1; data_in_push = 8'(8'hE0 + i);
      tick();
    end
    write = 1'b0; read = 1'b1;
    tick();
    chk("mid.occ",  32'(occupancy),    4);
    chk("mid.dout", 32'(data_out_pop), 8'hE0);
    write = 1'b1; data_in_push = 8'hE5;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    reset = 1'b0; read = 1'b0; write = 1'b1; data_in_push = 8'hF1;
    tick();
    write = 1'b0; read = 1'b1;
    tick();
    read = 1'b0;
    chk("post.dout",  32'(data_out_pop), 8'hF1);
    chk("post.valid", 32'(valid_out),    1);
    chk("post.occ",   32'(occupancy),    0);
    chk("post.err",   32'(fifo_error),   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
